trap_seq: RTL and testbench
===========================

Name: trap_seq

Overview:
- Trap entry/return sequencer, directly downstream of the exception/interrupt controller.
- Consumes the controller's exception/interrupt strobes and trap vector, and performs the architectural side effects:
  - MEPC save
  - MSTATUS MIE/MPIE/MPP update
  - PC redirect to the trap vector (direct or vectored)
  - MRET return
- Stalls the core for the duration of the sequence and counts taken traps.

Parameters:
- XLEN, 32, datapath width
- CAUSE_W, 5, width of interrupt cause code used for vectored offset
- FLUSH_CYCLES, 2, post-redirect stall cycles (pipeline drain), valid range 0..15

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- exception  input  1  synchronous exception strobe from the controller
- interrupt  input  1  interrupt strobe from the controller
- int_cause  input  CAUSE_W  interrupt cause code; valid with interrupt
- tvec  input  XLEN  MTVEC value: [XLEN-1:2] base, [1:0] mode
- mret  input  1  MRET retiring this cycle
- pc  input  XLEN  PC of the instruction currently executing
- mepc_reg  input  XLEN  current MEPC
- mie_reg  input  1  current MSTATUS.MIE
- mpie_reg  input  1  current MSTATUS.MPIE
- mepc_in  output  XLEN  MEPC write data
- mepc_write  output  1  MEPC write enable
- mie_in  output  1  MSTATUS.MIE write data
- mpie_in  output  1  MSTATUS.MPIE write data
- mpp_in  output  2  MSTATUS.MPP write data (always 2'b11)
- mstatus_write  output  1  MSTATUS MIE/MPIE/MPP write enable
- pc_target  output  XLEN  redirect target
- pc_write  output  1  PC redirect strobe
- busy  output  1  stall core; no new instruction may start
- trap_count  output  32  number of traps taken

Behaviour:
- Reset:
  - Synchronous, active-high: state=IDLE; all outputs 0 except mpp_in=2'b11; trap_count=0; internal captures cleared.
  - Reset mid-sequence aborts immediately; no further writes.
- States: IDLE, SAVE, VECTOR, RET, FLUSH.
- IDLE:
  - busy=0.
  - On exception|interrupt in cycle N:
    - Capture pc, interrupt flag (interrupt && !exception), int_cause, tvec.
    - Go to SAVE.
  - Else on mret: capture mepc_reg, go to RET.
  - exception/interrupt have priority over a simultaneous mret; the mret is dropped.
- SAVE (N+1):
  - busy=1.
  - mepc_write=1, mepc_in = captured pc with bit 0 cleared.
  - mstatus_write=1, mpie_in=mie_reg, mie_in=0, mpp_in=2'b11.
  - Go to VECTOR.
- VECTOR (N+2):
  - busy=1, pc_write=1.
  - base = {tvec[XLEN-1:2], 2'b00}.
  - Mode 01 with captured interrupt: pc_target = base + (zero-extended int_cause << 2), modulo 2^XLEN.
  - Otherwise (exception, mode 00, modes 10/11): pc_target = base.
  - trap_count increments by 1, wrapping at 2^32.
  - Go to FLUSH, or to IDLE if FLUSH_CYCLES=0.
- RET (N+1):
  - busy=1.
  - mstatus_write=1, mie_in=mpie_reg, mpie_in=1, mpp_in=2'b11.
  - pc_write=1, pc_target = captured mepc with bit 0 cleared.
  - Go to FLUSH, or to IDLE if FLUSH_CYCLES=0.
- FLUSH:
  - busy=1 for exactly FLUSH_CYCLES cycles (down-counter loaded on entry), then IDLE.
- Strobe exclusivity:
  - All write strobes (mepc_write, mstatus_write, pc_write) are single-cycle pulses.
  - No strobe is asserted in IDLE or FLUSH.
- Events outside IDLE:
  - exception/interrupt/mret arriving while not IDLE are ignored and not queued; busy guarantees the core produces none.
- Back-to-back: an exception in the first IDLE cycle after FLUSH is accepted normally; no dead cycle is required.
- Output timing:
  - busy is combinational from state (registered state only); it does not respond in cycle N.
  - The controller has already written MCAUSE in cycle N.

Test Plan:
- Exception, direct mode:
  - Stimulus: pc=0x0000_0104, tvec=0x8000_0001 (vectored), exception=1, mie_reg=1.
  - SAVE: mepc_in=0x104, mpie_in=1, mie_in=0.
  - VECTOR: pc_target=0x8000_0000 (exceptions ignore vectoring), trap_count=1.
  - busy high for 2+FLUSH_CYCLES cycles.
- Vectored interrupt:
  - Stimulus: tvec=0x8000_0001, interrupt=1, int_cause=7.
  - Response: pc_target=0x8000_001C. Same inputs with tvec=0x8000_0000 give pc_target=0x8000_0000.
- MRET:
  - Stimulus: mepc_reg=0x0000_0200, mpie_reg=1, mie_reg=0.
  - Response: one cycle later mstatus_write=1, mie_in=1, mpie_in=1, pc_target=0x200; no mepc_write; trap_count unchanged.
- Simultaneous exception+mret in IDLE: trap sequence only. Exception asserted during FLUSH: ignored, no strobes, trap_count unchanged.
- rst asserted in the SAVE cycle:
  - Next cycle: IDLE, busy=0, no pc_write, trap_count=0.
  - FLUSH_CYCLES=0 build: VECTOR returns straight to IDLE; busy is 2 cycles.
- Wrap: preload via 2^32-1 traps (or force) → next trap gives trap_count=0. Vectored target wraps: base 0xFFFF_FFF0, cause 7 → 0x0000_000C.

Source files
------------

// File: rtl/trap_seq.sv
// Trap entry / MRET return sequencer sitting behind the exception/interrupt controller.
// Latency: strobes appear the cycle after the event (SAVE/RET), PC redirect 1-2 cycles later, then FLUSH_CYCLES drain.
// Backpressure: busy holds the core off for the whole sequence; events arriving while busy are dropped.
//
// Ports:
//   clk, rst                      core clock, synchronous active-high reset
//   exception, interrupt, int_cause, tvec   trap request from the controller and MTVEC value
//   mret, pc, mepc_reg, mie_reg, mpie_reg   return request and current architectural state
//   mepc_in/mepc_write            MEPC write port
//   mie_in/mpie_in/mpp_in/mstatus_write     MSTATUS MIE/MPIE/MPP write port
//   pc_target/pc_write            PC redirect
//   busy                          stall request to the core
//   trap_count                    running count of taken traps (wraps)
module trap_seq #(
  parameter int XLEN         = 32,
  parameter int CAUSE_W      = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exception,
  input  logic               interrupt,
  input  logic [CAUSE_W-1:0] int_cause,
  input  logic [XLEN-1:0]    tvec,
  input  logic               mret,
  input  logic [XLEN-1:0]    pc,
  input  logic [XLEN-1:0]    mepc_reg,
  input  logic               mie_reg,
  input  logic               mpie_reg,
  output logic [XLEN-1:0]    mepc_in,
  output logic               mepc_write,
  output logic               mie_in,
  output logic               mpie_in,
  output logic [1:0]         mpp_in,
  output logic               mstatus_write,
  output logic [XLEN-1:0]    pc_target,
  output logic               pc_write,
  output logic               busy,
  output logic [31:0]        trap_count
);

  typedef enum logic [2:0] {IDLE, SAVE, VECTOR, RET, FLUSH} state_t;

  // FLUSH counts down to zero inclusive, so load one less than the cycle count.
  localparam logic [3:0] FLUSH_LOAD = 4'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
  localparam logic [XLEN-1:0] BIT0_CLR = {{(XLEN-1){1'b1}}, 1'b0};

  state_t               state_q, state_d;
  logic                 irq_cap_q, irq_cap_d;
  logic [CAUSE_W-1:0]   cause_cap_q, cause_cap_d;
  logic [XLEN-1:0]      tvec_cap_q, tvec_cap_d;
  logic [3:0]           flush_cnt_q, flush_cnt_d;
  logic [XLEN-1:0]      mepc_in_q, mepc_in_d;
  logic                 mepc_write_q, mepc_write_d;
  logic                 mie_in_q, mie_in_d;
  logic                 mpie_in_q, mpie_in_d;
  logic                 mstatus_write_q, mstatus_write_d;
  logic [XLEN-1:0]      pc_target_q, pc_target_d;
  logic                 pc_write_q, pc_write_d;
  logic [31:0]          trap_count_q, trap_count_d;

  logic [XLEN-1:0]      vec_base;
  logic [XLEN-1:0]      vec_off;
  logic [XLEN-1:0]      vec_target;

  // Only interrupts honour vectored mode; exceptions and reserved modes land on base.
  assign vec_base   = {tvec_cap_q[XLEN-1:2], 2'b00};
  assign vec_off    = {{(XLEN-CAUSE_W-2){1'b0}}, cause_cap_q, 2'b00};
  assign vec_target = (irq_cap_q && tvec_cap_q[1:0] == 2'b01) ? vec_base + vec_off : vec_base;

  // Outputs are registered: next-cycle values are decided on the transition into each state.
  always_comb begin
    state_d         = state_q;
    irq_cap_d       = irq_cap_q;
    cause_cap_d     = cause_cap_q;
    tvec_cap_d      = tvec_cap_q;
    flush_cnt_d     = flush_cnt_q;
    mepc_in_d       = mepc_in_q;
    mie_in_d        = mie_in_q;
    mpie_in_d       = mpie_in_q;
    pc_target_d     = pc_target_q;
    trap_count_d    = trap_count_q;
    mepc_write_d    = 1'b0;
    mstatus_write_d = 1'b0;
    pc_write_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (exception || interrupt) begin
          // Trap wins over a simultaneous mret, which is simply dropped.
          irq_cap_d       = interrupt && !exception;
          cause_cap_d     = int_cause;
          tvec_cap_d      = tvec;
          mepc_in_d       = pc & BIT0_CLR;
          mepc_write_d    = 1'b1;
          mpie_in_d       = mie_reg;
          mie_in_d        = 1'b0;
          mstatus_write_d = 1'b1;
          state_d         = SAVE;
        end else if (mret) begin
          mie_in_d        = mpie_reg;
          mpie_in_d       = 1'b1;
          mstatus_write_d = 1'b1;
          pc_target_d     = mepc_reg & BIT0_CLR;
          pc_write_d      = 1'b1;
          state_d         = RET;
        end
      end
      SAVE: begin
        pc_target_d  = vec_target;
        pc_write_d   = 1'b1;
        trap_count_d = trap_count_q + 32'd1;
        state_d      = VECTOR;
      end
      VECTOR, RET: begin
        if (FLUSH_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          flush_cnt_d = FLUSH_LOAD;
          state_d     = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      irq_cap_q       <= 1'b0;
      cause_cap_q     <= '0;
      tvec_cap_q      <= '0;
      flush_cnt_q     <= '0;
      mepc_in_q       <= '0;
      mepc_write_q    <= 1'b0;
      mie_in_q        <= 1'b0;
      mpie_in_q       <= 1'b0;
      mstatus_write_q <= 1'b0;
      pc_target_q     <= '0;
      pc_write_q      <= 1'b0;
      trap_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      irq_cap_q       <= irq_cap_d;
      cause_cap_q     <= cause_cap_d;
      tvec_cap_q      <= tvec_cap_d;
      flush_cnt_q     <= flush_cnt_d;
      mepc_in_q       <= mepc_in_d;
      mepc_write_q    <= mepc_write_d;
      mie_in_q        <= mie_in_d;
      mpie_in_q       <= mpie_in_d;
      mstatus_write_q <= mstatus_write_d;
      pc_target_q     <= pc_target_d;
      pc_write_q      <= pc_write_d;
      trap_count_q    <= trap_count_d;
    end
  end

  assign mepc_in       = mepc_in_q;
  assign mepc_write    = mepc_write_q;
  assign mie_in        = mie_in_q;
  assign mpie_in       = mpie_in_q;
  assign mpp_in        = 2'b11;
  assign mstatus_write = mstatus_write_q;
  assign pc_target     = pc_target_q;
  assign pc_write      = pc_write_q;
  assign trap_count    = trap_count_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_trap_seq.sv
// Bench for trap_seq: a FLUSH_CYCLES=2 instance plus a FLUSH_CYCLES=0 instance sharing stimulus.
module tb_trap_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exception = 1'b0;
  logic        interrupt = 1'b0;
  logic [4:0]  int_cause = '0;
  logic [31:0] tvec = '0;
  logic        mret = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] mepc_reg = '0;
  logic        mie_reg = 1'b0;
  logic        mpie_reg = 1'b0;
  logic        en0 = 1'b1;

  logic [31:0] mepc_in, pc_target, trap_count;
  logic        mepc_write, mie_in, mpie_in, mstatus_write, pc_write, busy;
  logic [1:0]  mpp_in;

  logic [31:0] mepc_in0, pc_target0, trap_count0;
  logic        mepc_write0, mie_in0, mpie_in0, mstatus_write0, pc_write0, busy0;
  logic [1:0]  mpp_in0;

  always #5 clk = ~clk;

  trap_seq dut (
    .clk(clk), .rst(rst), .exception(exception), .interrupt(interrupt),
    .int_cause(int_cause), .tvec(tvec), .mret(mret), .pc(pc),
    .mepc_reg(mepc_reg), .mie_reg(mie_reg), .mpie_reg(mpie_reg),
    .mepc_in(mepc_in), .mepc_write(mepc_write), .mie_in(mie_in), .mpie_in(mpie_in),
    .mpp_in(mpp_in), .mstatus_write(mstatus_write), .pc_target(pc_target),
    .pc_write(pc_write), .busy(busy), .trap_count(trap_count)
  );

  trap_seq #(.FLUSH_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .exception(exception && en0), .interrupt(interrupt && en0),
    .int_cause(int_cause), .tvec(tvec), .mret(mret && en0), .pc(pc),
    .mepc_reg(mepc_reg), .mie_reg(mie_reg), .mpie_reg(mpie_reg),
    .mepc_in(mepc_in0), .mepc_write(mepc_write0), .mie_in(mie_in0), .mpie_in(mpie_in0),
    .mpp_in(mpp_in0), .mstatus_write(mstatus_write0), .pc_target(pc_target0),
    .pc_write(pc_write0), .busy(busy0), .trap_count(trap_count0)
  );

  typedef struct packed {
    logic        busy;
    logic        busy0;
    logic        mepc_write;
    logic        mstatus_write;
    logic        pc_write;
    logic [31:0] mepc_in;
    logic        mie_in;
    logic        mpie_in;
    logic [1:0]  mpp_in;
    logic [31:0] pc_target;
    logic [31:0] trap_count;
  } obs_t;

  typedef struct {
    logic        exc;
    logic        irq;
    logic [4:0]  cause;
    logic [31:0] tvec;
    logic [31:0] pc;
    logic        mret;
    logic [31:0] mepc_reg;
    logic        mie;
    logic        mpie;
    logic        trap;
    logic [31:0] e_mepc;
    logic        e_mie;
    logic        e_mpie;
    logic [31:0] e_tgt;
    logic [31:0] e_cnt;
  } vec_t;

  obs_t exp_q[$];
  obs_t msk_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t V(logic exc, logic irq, logic [4:0] cause, logic [31:0] tv,
                             logic [31:0] p, logic mr, logic [31:0] me, logic mi, logic mp,
                             logic trap, logic [31:0] e_mepc, logic e_mie, logic e_mpie,
                             logic [31:0] e_tgt, logic [31:0] e_cnt);
    vec_t v;
    v.exc = exc; v.irq = irq; v.cause = cause; v.tvec = tv; v.pc = p;
    v.mret = mr; v.mepc_reg = me; v.mie = mi; v.mpie = mp;
    v.trap = trap; v.e_mepc = e_mepc; v.e_mie = e_mie; v.e_mpie = e_mpie;
    v.e_tgt = e_tgt; v.e_cnt = e_cnt;
    return v;
  endfunction

  function automatic obs_t mk(logic b, logic b0, logic mw, logic sw, logic pw, logic [31:0] me,
                              logic mi, logic mp, logic [31:0] tg, logic [31:0] c);
    obs_t o;
    o.busy = b; o.busy0 = b0; o.mepc_write = mw; o.mstatus_write = sw; o.pc_write = pw;
    o.mepc_in = me; o.mie_in = mi; o.mpie_in = mp; o.mpp_in = 2'b11;
    o.pc_target = tg; o.trap_count = c;
    return o;
  endfunction

  // Care mask: control/count always checked, data only when its strobe is expected.
  function automatic obs_t mkm(logic mw, logic sw, logic pw);
    obs_t m;
    m = '0;
    m.busy = 1'b1; m.busy0 = 1'b1; m.mepc_write = 1'b1; m.mstatus_write = 1'b1;
    m.pc_write = 1'b1; m.mpp_in = 2'b11; m.trap_count = '1;
    if (mw) m.mepc_in = '1;
    if (sw) begin m.mie_in = 1'b1; m.mpie_in = 1'b1; end
    if (pw) m.pc_target = '1;
    return m;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.busy = busy; o.busy0 = busy0; o.mepc_write = mepc_write;
    o.mstatus_write = mstatus_write; o.pc_write = pc_write; o.mepc_in = mepc_in;
    o.mie_in = mie_in; o.mpie_in = mpie_in; o.mpp_in = mpp_in;
    o.pc_target = pc_target; o.trap_count = trap_count;
    return o;
  endfunction

  task automatic push(input obs_t e, input obs_t m);
    exp_q.push_back(e);
    msk_q.push_back(m);
  endtask

  task automatic check(input string tag);
    obs_t a, e, m;
    a = sample();
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: no expected record queued, got %h", tag, a);
    end else begin
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      if (((a ^ e) & m) != '0)
        begin
          n_bad++;
          $display("FAIL %s: got %h expected %h (care mask %h)", tag, a, e, m);
        end
    end
  endtask

  task automatic clear_req();
    exception = 1'b0; interrupt = 1'b0; mret = 1'b0;
  endtask

  // Drive one event in an IDLE cycle and check every cycle of the resulting sequence.
  // inj > 0 asserts all three requests again at that cycle offset (main DUT only).
  task automatic do_event(input vec_t v, input int inj, input int id);
    logic [31:0] prev;
    int n;
    prev = v.trap ? v.e_cnt - 32'd1 : v.e_cnt;
    push(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, prev), mkm(0, 0, 0));
    if (v.trap) begin
      push(mk(1, 1, 1, 1, 0, v.e_mepc, v.e_mie, v.e_mpie, 0, prev), mkm(1, 1, 0));
      push(mk(1, 1, 0, 0, 1, 0, 0, 0, v.e_tgt, v.e_cnt), mkm(0, 0, 1));
      push(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, v.e_cnt), mkm(0, 0, 0));
      push(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, v.e_cnt), mkm(0, 0, 0));
      n = 5;
    end else begin
      push(mk(1, 1, 0, 1, 1, 0, v.e_mie, v.e_mpie, v.e_tgt, prev), mkm(0, 1, 1));
      push(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, prev), mkm(0, 0, 0));
      push(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, prev), mkm(0, 0, 0));
      n = 4;
    end
    @(negedge clk);
    exception = v.exc; interrupt = v.irq; int_cause = v.cause; tvec = v.tvec;
    pc = v.pc; mret = v.mret; mepc_reg = v.mepc_reg; mie_reg = v.mie; mpie_reg = v.mpie;
    #1 check($sformatf("ev%0d c0", id));
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      if (k == 1) clear_req();
      if (k == inj) begin
        exception = 1'b1; interrupt = 1'b1; mret = 1'b1; en0 = 1'b0;
      end else if (k == inj + 1) begin
        clear_req(); en0 = 1'b1;
      end
      #1 check($sformatf("ev%0d c%0d", id, k));
    end
    clear_req();
    en0 = 1'b1;
  endtask

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = V(1, 0, 0, 32'h8000_0001, 32'h0000_0104, 0, 0, 1, 0,
               1, 32'h0000_0104, 0, 1, 32'h8000_0000, 1);
    tbl[1] = V(0, 1, 7, 32'h8000_0001, 32'h0000_2000, 0, 0, 1, 0,
               1, 32'h0000_2000, 0, 1, 32'h8000_001C, 2);
    tbl[2] = V(0, 1, 7, 32'h8000_0000, 32'h0000_3001, 0, 0, 0, 1,
               1, 32'h0000_3000, 0, 0, 32'h8000_0000, 3);
    tbl[3] = V(0, 0, 0, 32'h0, 32'h0000_5000, 1, 32'h0000_0200, 0, 1,
               0, 32'h0, 1, 1, 32'h0000_0200, 3);
    tbl[4] = V(1, 0, 0, 32'h0000_0100, 32'h0000_0400, 1, 32'h0000_0999, 1, 1,
               1, 32'h0000_0400, 0, 1, 32'h0000_0100, 4);
    tbl[5] = V(0, 1, 3, 32'h4000_0003, 32'h0000_0040, 0, 0, 1, 0,
               1, 32'h0000_0040, 0, 1, 32'h4000_0000, 5);
    tbl[6] = V(0, 1, 7, 32'hFFFF_FFF1, 32'h0000_0044, 0, 0, 1, 0,
               1, 32'h0000_0044, 0, 1, 32'h0000_000C, 6);
    tbl[7] = V(0, 0, 0, 32'h0, 32'h0, 1, 32'h0000_0201, 1, 0,
               0, 32'h0, 0, 1, 32'h0000_0200, 6);
    tbl[8] = V(1, 1, 5, 32'h8000_0001, 32'h0000_0088, 0, 0, 0, 0,
               1, 32'h0000_0088, 0, 0, 32'h8000_0000, 7);
    tbl[9] = V(0, 1, 31, 32'h0000_1001, 32'h0000_0090, 0, 0, 1, 1,
               1, 32'h0000_0090, 0, 1, 32'h0000_107C, 8);

    // Reset state: everything zero except MPP.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    push(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), '1);
    #1 check("reset state");

    // Back-to-back table: each event starts in the first IDLE cycle after the previous one.
    for (int i = 0; i < 10; i++) do_event(tbl[i], -1, i);

    // Requests during FLUSH are ignored: no strobes, count unchanged.
    do_event(V(1, 0, 0, 32'h0000_0600, 32'h0000_0500, 0, 0, 0, 0,
               1, 32'h0000_0500, 0, 0, 32'h0000_0600, 9), 3, 10);

    // Preload the counter to all-ones; the next trap wraps it to zero.
    @(negedge clk);
    force dut.trap_count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.trap_count_q;
    do_event(V(1, 0, 0, 32'h0000_0010, 32'h0000_0006, 0, 0, 1, 0,
               1, 32'h0000_0006, 0, 1, 32'h0000_0010, 0), -1, 11);

    // Reset asserted during SAVE aborts the sequence with no redirect.
    @(negedge clk);
    exception = 1'b1; pc = 32'h0000_0700; tvec = 32'h0000_0800; mie_reg = 1'b1;
    @(negedge clk);
    clear_req();
    rst = 1'b1;
    push(mk(1, 1, 1, 1, 0, 32'h0000_0700, 0, 1, 0, 32'h0), mkm(1, 1, 0));
    #1 check("rst save cycle");
    @(negedge clk);
    rst = 1'b0;
    push(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), '1);
    #1 check("rst abort");
    @(negedge clk);
    push(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mkm(0, 0, 0));
    #1 check("rst no redirect");

    // Normal operation resumes with the counter restarted.
    do_event(V(1, 0, 0, 32'h8000_0001, 32'h0000_0104, 0, 0, 1, 0,
               1, 32'h0000_0104, 0, 1, 32'h8000_0000, 1), -1, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
